// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer: FSM states,
// sample-rate select codes and frame geometry.
package acq_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 10;
    localparam int DATA_NUM = 405;
    localparam int WD_W     = 28;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_WAIT_START,
        ST_CAPTURE,
        ST_FRAME_READY
    } acq_state_t;

    // Bit 1 set selects real-time mode regardless of bit 0.
    typedef enum logic [1:0] {
        RATE_200M  = 2'b00,
        RATE_10M   = 2'b01,
        RATE_RT_1K = 2'b10
    } rate_sel_t;

    function automatic logic wd_active(input acq_state_t s);
        return (s == ST_REQUEST) || (s == ST_WAIT_START) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// Sampler handshake, frame RAM write port and frame-ready handshake
// between the sequencer (master) and its sampler/sender peers (slave).
interface acq_sequencer_if;

    logic                          out_request_n;
    logic [1:0]                    out_sample_rate_select;
    logic                          in_measure_sig;
    logic                          in_adc_clk;
    logic [acq_pkg::DATA_W-1:0]    in_adc_data;
    logic                          out_wr_en;
    logic [acq_pkg::ADDR_W-1:0]    out_wr_addr;
    logic [acq_pkg::DATA_W-1:0]    out_wr_data;
    logic                          out_frame_ready;
    logic [acq_pkg::ADDR_W-1:0]    out_frame_len;
    logic                          in_frame_ack;

    modport master (
        output out_request_n, out_sample_rate_select,
        output out_wr_en, out_wr_addr, out_wr_data,
        output out_frame_ready, out_frame_len,
        input  in_measure_sig, in_adc_clk, in_adc_data, in_frame_ack
    );

    modport slave (
        input  out_request_n, out_sample_rate_select,
        input  out_wr_en, out_wr_addr, out_wr_data,
        input  out_frame_ready, out_frame_len,
        output in_measure_sig, in_adc_clk, in_adc_data, in_frame_ack
    );

endinterface

// File: rtl/acq_watchdog.sv
// Loadable watchdog counter; expired pulses for one cycle when the count,
// while enabled, is about to reach TIMEOUT_CNT.
module acq_watchdog
    import acq_pkg::*;
#(
    parameter logic [WD_W-1:0] TIMEOUT_CNT = 28'd100_000_000
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            clr,
    input  logic            en,
    input  logic            ld,
    input  logic [WD_W-1:0] ld_val,
    output logic            expired
);

    logic [WD_W-1:0] cnt;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (en) begin
            cnt <= cnt + WD_W'(1);
        end
    end

    // A pending clear means the count is stale from a previous state.
    assign expired = en && !clr && !ld && (cnt == TIMEOUT_CNT - WD_W'(1));

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: requests a frame from the sampler, captures ADC
// bytes into frame RAM on each ADC clock edge and hands the frame to the sender.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int              DATA_NUM      = acq_pkg::DATA_NUM,
    parameter int              REQ_PULSE_CNT = 4,
    parameter logic [WD_W-1:0] TIMEOUT_CNT   = 28'd100_000_000
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_start,
    input  logic              in_abort,
    input  logic              in_continuous,
    input  logic [1:0]        in_rate_sel,
    acq_sequencer_if.master   bus,
    output logic              out_busy,
    output logic              out_timeout
);

    localparam logic [ADDR_W-1:0] DATA_NUM_C = ADDR_W'(DATA_NUM);
    localparam logic [7:0]        PULSE_LAST = 8'(REQ_PULSE_CNT - 1);

    acq_state_t        state;
    logic [ADDR_W-1:0] count;
    logic [7:0]        pulse_cnt;
    logic              adc_clk_p1;
    logic              measure_p1;
    logic              acked;
    logic              wd_clr;
    logic              wd_en;
    logic              wd_expired;
    logic              adc_edge;
    logic              measure_fall;
    logic              take_sample;

    // Stage p1: previous-cycle copies for edge detection
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            adc_clk_p1 <= 1'b0;
            measure_p1 <= 1'b0;
        end else begin
            adc_clk_p1 <= bus.in_adc_clk;
            measure_p1 <= bus.in_measure_sig;
        end
    end

    assign adc_edge     = bus.in_adc_clk && !adc_clk_p1;
    assign measure_fall = measure_p1 && !bus.in_measure_sig;
    assign take_sample  = adc_edge && (count < DATA_NUM_C);
    assign out_busy     = (state != ST_IDLE);
    assign wd_en        = wd_active(state);

    acq_watchdog #(
        .TIMEOUT_CNT(TIMEOUT_CNT)
    ) u_watchdog (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .ld     (1'b0),
        .ld_val ('0),
        .expired(wd_expired)
    );

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state                      <= ST_IDLE;
            bus.out_request_n          <= 1'b1;
            bus.out_sample_rate_select <= 2'b00;
            bus.out_wr_en              <= 1'b0;
            bus.out_wr_addr            <= '0;
            bus.out_wr_data            <= '0;
            bus.out_frame_ready        <= 1'b0;
            bus.out_frame_len          <= '0;
            out_timeout                <= 1'b0;
            count                      <= '0;
            pulse_cnt                  <= '0;
            acked                      <= 1'b0;
            wd_clr                     <= 1'b0;
        end else begin
            bus.out_wr_en <= 1'b0;
            wd_clr        <= 1'b0;
            if (in_abort) begin
                state               <= ST_IDLE;
                bus.out_request_n   <= 1'b1;
                bus.out_frame_ready <= 1'b0;
                acked               <= 1'b0;
            end else if (wd_expired) begin
                // Clearing acked blocks continuous re-arm until a fresh start.
                state             <= ST_IDLE;
                bus.out_request_n <= 1'b1;
                out_timeout       <= 1'b1;
                acked             <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if ((in_start || (in_continuous && acked)) && !bus.in_measure_sig) begin
                            state                      <= ST_REQUEST;
                            bus.out_request_n          <= 1'b0;
                            bus.out_sample_rate_select <= in_rate_sel;
                            pulse_cnt                  <= '0;
                            acked                      <= 1'b0;
                            wd_clr                     <= 1'b1;
                            if (in_start) begin
                                out_timeout <= 1'b0;
                            end
                        end
                    end
                    ST_REQUEST: begin
                        if (pulse_cnt == PULSE_LAST) begin
                            state             <= ST_WAIT_START;
                            bus.out_request_n <= 1'b1;
                            wd_clr            <= 1'b1;
                        end else begin
                            pulse_cnt <= pulse_cnt + 8'd1;
                        end
                    end
                    ST_WAIT_START: begin
                        if (bus.in_measure_sig) begin
                            state           <= ST_CAPTURE;
                            count           <= '0;
                            bus.out_wr_addr <= '0;
                            wd_clr          <= 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        if (take_sample) begin
                            bus.out_wr_en   <= 1'b1;
                            bus.out_wr_addr <= count;
                            bus.out_wr_data <= bus.in_adc_data;
                            count           <= count + ADDR_W'(1);
                            wd_clr          <= 1'b1;
                        end
                        // A sample taken in the closing cycle still counts.
                        if (measure_fall) begin
                            state               <= ST_FRAME_READY;
                            bus.out_frame_ready <= 1'b1;
                            bus.out_frame_len   <= count + ADDR_W'(take_sample);
                        end
                    end
                    ST_FRAME_READY: begin
                        if (bus.in_frame_ack) begin
                            state               <= ST_IDLE;
                            bus.out_frame_ready <= 1'b0;
                            acked               <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: a sampler model feeds random ADC bytes and a
// frame-level reference queue predicts every RAM write.
module tb_acq_sequencer;

    import acq_pkg::*;

    localparam int DN  = 405;
    localparam int RPC = 4;
    localparam int TO  = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       cont;
    logic [1:0] rate;
    logic       busy;
    logic       timeout;

    acq_sequencer_if bus();

    acq_sequencer #(
        .DATA_NUM     (DN),
        .REQ_PULSE_CNT(RPC),
        .TIMEOUT_CNT  (28'(TO))
    ) dut (
        .in_clk       (clk),
        .in_rst       (rst),
        .in_start     (start),
        .in_abort     (abort),
        .in_continuous(cont),
        .in_rate_sel  (rate),
        .bus          (bus),
        .out_busy     (busy),
        .out_timeout  (timeout)
    );

    always #5 clk = ~clk;

    int          n_total   = 0;
    int          n_bad     = 0;
    int          n_req     = 0;
    int          low_run   = 0;
    int          last_addr = -1;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Request pulse width and count
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            low_run = 0;
        end else if (bus.out_request_n === 1'b0) begin
            low_run++;
        end else if (low_run != 0) begin
            check_val("req_width", low_run, RPC);
            n_req++;
            low_run = 0;
        end
    end

    // Every RAM write must match the next predicted (addr, byte)
    always @(negedge clk) begin
        if (bus.out_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("wr_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("wr_addr", bus.out_wr_addr, mon_e[17:8]);
                check_val("wr_data", bus.out_wr_data, mon_e[7:0]);
            end
            last_addr = bus.out_wr_addr;
        end
    end

    task automatic chk_reset(input string pfx);
        check_val({pfx, "_req_n"}, bus.out_request_n, 1);
        check_val({pfx, "_rate"}, bus.out_sample_rate_select, 0);
        check_val({pfx, "_wr_en"}, bus.out_wr_en, 0);
        check_val({pfx, "_wr_addr"}, bus.out_wr_addr, 0);
        check_val({pfx, "_wr_data"}, bus.out_wr_data, 0);
        check_val({pfx, "_frame_ready"}, bus.out_frame_ready, 0);
        check_val({pfx, "_frame_len"}, bus.out_frame_len, 0);
        check_val({pfx, "_busy"}, busy, 0);
        check_val({pfx, "_timeout"}, timeout, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sampler model: answers one request with n ADC edges; stop_at < n cuts the
    // frame short with an abort (stop_rst=0) or an async reset (stop_rst=1).
    task automatic run_frame(input int n, input bit coinc, input int stop_at, input bit stop_rst,
                             input logic [1:0] exp_rate, input logic [1:0] nxt_rate);
        int         w;
        logic [7:0] d;
        w = 0;
        while (bus.out_request_n !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("req_seen", bus.out_request_n, 0);
        check_val("rate_latch", bus.out_sample_rate_select, exp_rate);
        w = 0;
        while (bus.out_request_n !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        bus.in_measure_sig = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            if (k == stop_at) begin
                if (stop_rst) begin
                    rst = 1'b0;
                    #1;
                    chk_reset("rst_mid");
                end else begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check_val("abort_busy", busy, 0);
                    check_val("abort_ready", bus.out_frame_ready, 0);
                    check_val("abort_req_n", bus.out_request_n, 1);
                end
                bus.in_measure_sig = 1'b0;
                bus.in_adc_clk     = 1'b0;
                return;
            end
            bus.in_adc_clk = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            d = 8'($urandom);
            bus.in_adc_data = d;
            bus.in_adc_clk  = 1'b1;
            if (k < DN) exp_q.push_back({10'(k), d});
            if (k == n / 2) rate = nxt_rate;
            if (coinc && k == n - 1) bus.in_measure_sig = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bus.in_adc_clk = 1'b0;
        @(negedge clk);
        bus.in_measure_sig = 1'b0;
        @(negedge clk);
        check_val("rate_hold", bus.out_sample_rate_select, exp_rate);
    endtask

    task automatic wait_frame(input int exp_len);
        int w;
        w = 0;
        while (bus.out_frame_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_val("frame_ready_set", bus.out_frame_ready, 1);
        check_val("frame_len", bus.out_frame_len, exp_len);
        repeat (3) @(negedge clk);
        check_val("frame_ready_hold", bus.out_frame_ready, 1);
        bus.in_frame_ack = 1'b1;
        @(negedge clk);
        bus.in_frame_ack = 1'b0;
        check_val("frame_ready_clr", bus.out_frame_ready, 0);
        check_val("idle_after_ack", busy, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_time_limit: got=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [1:0] rs[4];
        int         base;
        int         nedg;
        int         w;
        rst = 1'b0;  start = 1'b0;  abort = 1'b0;  cont = 1'b0;  rate = 2'b00;
        bus.in_measure_sig = 1'b0;
        bus.in_adc_clk     = 1'b0;
        bus.in_adc_data    = '0;
        bus.in_frame_ack   = 1'b0;
        @(negedge clk);
        chk_reset("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Full frame, last edge coincides with measure falling
        rate = 2'b01;
        pulse_start();
        run_frame(DN, 1'b1, -1, 1'b0, 2'b01, 2'b10);
        wait_frame(DN);
        check_val("f1_queue_left", exp_q.size(), 0);
        check_val("f1_last_addr", last_addr, DN - 1);

        // Overlong frame saturates without wrap
        rate = 2'b11;
        pulse_start();
        run_frame(DN + 5, 1'b0, -1, 1'b0, 2'b11, 2'b00);
        wait_frame(DN);
        check_val("f2_queue_left", exp_q.size(), 0);
        check_val("f2_last_addr", last_addr, DN - 1);

        // Continuous mode, new rate latched per frame
        for (int i = 0; i < 4; i++) rs[i] = 2'($urandom_range(0, 3));
        rate = rs[0];
        cont = 1'b1;
        base = n_req;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            nedg = $urandom_range(20, 60);
            run_frame(nedg, 1'b0, -1, 1'b0, rs[f], rs[f + 1]);
            if (f == 2) cont = 1'b0;
            wait_frame(nedg);
        end
        repeat (10) @(negedge clk);
        check_val("cont_requests", n_req - base, 3);
        check_val("cont_idle", busy, 0);
        check_val("cont_queue_left", exp_q.size(), 0);

        // Watchdog: sampler never answers
        rate = 2'b10;
        base = n_req;
        pulse_start();
        cont = 1'b1;
        w = 0;
        while (timeout !== 1'b1 && w < TO + 100) begin
            @(negedge clk);
            w++;
        end
        check_val("to_flag", timeout, 1);
        check_val("to_busy", busy, 0);
        check_val("to_window", (w >= TO) && (w <= TO + 20), 1);
        repeat (20) @(negedge clk);
        check_val("to_no_rearm", n_req - base, 1);
        check_val("to_still_idle", busy, 0);
        cont = 1'b0;

        // Start clears timeout; abort at sample 200
        rate = 2'b01;
        pulse_start();
        check_val("start_clears_to", timeout, 0);
        run_frame(300, 1'b0, 200, 1'b0, 2'b01, 2'b01);
        check_val("abort_queue_left", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        check_val("abort_no_ready", bus.out_frame_ready, 0);

        // Abort and start together
        base  = n_req;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_val("abort_start_busy", busy, 0);
        repeat (10) @(negedge clk);
        check_val("abort_start_noreq", n_req - base, 0);

        // Stray ack outside FRAME_READY must not arm continuous mode
        cont = 1'b1;
        bus.in_frame_ack = 1'b1;
        @(negedge clk);
        bus.in_frame_ack = 1'b0;
        repeat (10) @(negedge clk);
        check_val("stray_ack_busy", busy, 0);
        check_val("stray_ack_noreq", n_req - base, 0);
        cont = 1'b0;

        // Start while sampler busy is ignored, rate not latched
        bus.in_measure_sig = 1'b1;
        rate = 2'b11;
        pulse_start();
        @(negedge clk);
        check_val("busy_start_ign", busy, 0);
        check_val("busy_start_rate", bus.out_sample_rate_select, 2'b01);
        bus.in_measure_sig = 1'b0;
        repeat (5) @(negedge clk);
        check_val("busy_start_late", busy, 0);

        // Async reset at sample 100
        cont = 1'b1;
        rate = 2'b10;
        pulse_start();
        run_frame(300, 1'b0, 100, 1'b1, 2'b10, 2'b10);
        check_val("rst_queue_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        base = n_req;
        repeat (20) @(negedge clk);
        check_val("rst_noreq", n_req - base, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_no_ready", bus.out_frame_ready, 0);
        cont = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter DATA_NUM, default 405, max samples per frame (matches sampler frame length).
REQ-002 SHALL have parameter REQ_PULSE_CNT, default 4, out_request_n low width in in_clk cycles.
REQ-003 SHALL have parameter TIMEOUT_CNT, default 28'd100_000_000, watchdog limit in in_clk cycles (0.5 s at 200 MHz).
REQ-004 in_clk  input  1  system clock, 200 MHz.
REQ-005 in_rst  input  1  reset, asynchronous, active-low.
REQ-006 in_start  input  1  one-cycle start-acquisition pulse.
REQ-007 in_abort  input  1  one-cycle abort pulse.
REQ-008 in_continuous  input  1  1 = re-arm automatically after each acknowledged frame.
REQ-009 in_rate_sel  input  2  requested sample-rate select; [1]=1 real-time 1 kHz, else [0]=1 10 MHz / 0 200 MHz equivalent.
REQ-010 in_measure_sig  input  1  sampler busy (high for whole frame).
REQ-011 in_adc_clk  input  1  sampler ADC clock, in_clk-synchronous.
REQ-012 in_adc_data  input  8  ADC output byte.
REQ-013 out_request_n  output  1  sampling request to sampler, active low.
REQ-014 out_sample_rate_select  output  2  latched rate select to sampler.
REQ-015 out_wr_en / out_wr_addr / out_wr_data  output  1/10/8  frame RAM write port.
REQ-016 out_frame_ready  output  1  frame complete, held until acknowledged.
REQ-017 out_frame_len  output  10  valid samples in frame.
REQ-018 in_frame_ack  input  1  one-cycle pulse from sender, in_clk-synchronous.
REQ-019 out_busy  output  1  high in any state except IDLE.
REQ-020 out_timeout  output  1  sticky watchdog error flag.

Function
REQ-021 SHALL implement FSM states IDLE, REQUEST, WAIT_START, CAPTURE, FRAME_READY.
REQ-022 IDLE -> REQUEST when (in_start or (in_continuous and previous frame acked)) and in_measure_sig==0; in_rate_sel latched to out_sample_rate_select that cycle; out_timeout cleared on in_start.
REQ-023 in_start while in_measure_sig==1 in IDLE: ignored, no latch.
REQ-024 REQUEST: out_request_n low exactly REQ_PULSE_CNT cycles, then high and -> WAIT_START.
REQ-025 WAIT_START -> CAPTURE on in_measure_sig==1; wr_addr cleared to 0.
REQ-026 CAPTURE: on in_adc_clk rising edge (registered compare, prev 0 / now 1) assert out_wr_en one cycle, out_wr_data = in_adc_data sampled on that edge cycle, out_wr_addr = current count; count increments next cycle.
REQ-027 Count saturates at DATA_NUM; edges beyond DATA_NUM produce no write, no wrap.
REQ-028 CAPTURE -> FRAME_READY on in_measure_sig falling edge; an ADC edge in the same cycle is still written; out_frame_len = final count.
REQ-029 FRAME_READY: out_frame_ready=1 until in_frame_ack; then -> IDLE; continuous re-arm evaluated next cycle per REQ-022.
REQ-030 Watchdog counter (28 bit) runs in REQUEST, WAIT_START, CAPTURE; cleared on each state entry except within CAPTURE where it resets on each written sample; reaching TIMEOUT_CNT sets out_timeout, -> IDLE, continuous re-arm suppressed until next in_start.
REQ-031 in_abort in any state: -> IDLE next cycle, out_request_n high, out_wr_en low, out_frame_ready low; out_timeout unchanged.
REQ-032 in_abort and in_start same cycle: abort wins, start dropped.
REQ-033 in_frame_ack outside FRAME_READY: ignored.
REQ-034 out_sample_rate_select SHALL NOT change outside the IDLE->REQUEST transition.

Reset
REQ-035 Async assert: state IDLE, out_request_n=1, out_sample_rate_select=2'b00, out_wr_en=0, out_wr_addr=0, out_wr_data=0, out_frame_ready=0, out_frame_len=0, out_busy=0, out_timeout=0, watchdog=0.
REQ-036 Reset mid-CAPTURE: partial frame discarded, no frame_ready; first frame after release requires new in_start.

Structure
REQ-037 Shared package acq_pkg: FSM state enumeration, rate-select encodings, DATA_NUM, address/data widths.
REQ-038 One sub-module acq_watchdog: loadable 28-bit counter with clear, enable, expired pulse.

Verification
REQ-039 in_start, rate 2'b01, sampler model gives measure_sig high 405 ADC edges -> out_request_n low 4 cycles, 405 writes addr 0..404, out_frame_len=405, frame_ready until ack.
REQ-040 Sampler emits 410 ADC edges -> exactly 405 writes, last addr 404, no wrap.
REQ-041 measure_sig never rises after request -> out_timeout=1 after 100_000_000 cycles, state IDLE, busy=0.
REQ-042 in_continuous=1, three acks -> three request pulses, rate latched once per frame; rate change mid-CAPTURE not visible on output.
REQ-043 in_abort at sample 200 -> IDLE next cycle, no frame_ready; abort+start same cycle -> no request.
REQ-044 in_rst low mid-CAPTURE at sample 100 -> all outputs at reset values immediately; no re-request without in_start.
